// File: rtl/data_mem_bridge_pkg.sv
// Shared definitions for the data-memory bridge: FSM encodings and the default bus-wait limit.
package data_mem_bridge_pkg;

    typedef enum logic [1:0] {
        DMB_IDLE = 2'd0,
        DMB_BUSY = 2'd1,
        DMB_HOLD = 2'd2
    } dmb_state_e;

    localparam int DMB_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/data_mem_bridge_if.sv
// Wishbone-style data bus between the bridge (master) and the memory/peripheral side (slave).
interface data_mem_bridge_if;

    logic        bus_cyc_o;
    logic        bus_stb_o;
    logic        bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_adr_o;
    logic [31:0] bus_dat_o;
    logic [31:0] bus_dat_i;
    logic        bus_ack_i;
    logic        bus_err_o;

    modport master (
        output bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o, bus_adr_o, bus_dat_o, bus_err_o,
        input  bus_dat_i, bus_ack_i
    );

    modport slave (
        input  bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o, bus_adr_o, bus_dat_o, bus_err_o,
        output bus_dat_i, bus_ack_i
    );

endinterface

// File: rtl/data_mem_bridge_timer.sv
// Bus-wait counter for data_mem_bridge: cleared at the start of an access, counts BUSY cycles without ack.
module data_mem_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [7:0] LAST = 8'(LIMIT - 1);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 8'd0;
        end else if (en_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expires in the LIMIT-th waiting cycle, so the bus is released after exactly LIMIT BUSY cycles.
    assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/data_mem_bridge.sv
// Sequential bridge from the memory-access stage to a wait-stated Wishbone-style data bus.
// Optional bus-wait timeout is enabled by defining DATA_MEM_BRIDGE_TIMEOUT_EN.
module data_mem_bridge
    import data_mem_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DMB_TIMEOUT_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ram_ce_i,
    input  logic                      ram_we_i,
    input  logic [3:0]                ram_sel_i,
    input  logic [31:0]               ram_addr_i,
    input  logic [31:0]               ram_wdata_i,
    output logic [31:0]               ram_rdata_o,
    input  logic                      stall_i,
    input  logic                      flush_i,
    output logic                      stallreq_o,
    data_mem_bridge_if.master         bus
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("data_mem_bridge: TIMEOUT_CYCLES must be in 1..255");
    end

    dmb_state_e  state_q, state_d;
    logic        drop_q, drop_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [31:0] rdata_q, rdata_d;
    logic        drop_now;

`ifdef DATA_MEM_BRIDGE_TIMEOUT_EN
    logic err_q, err_d;
    logic tmr_clr, tmr_en, tmr_expire;

    data_mem_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (tmr_clr),
        .en_i     (tmr_en),
        .expire_o (tmr_expire)
    );

    assign tmr_clr = (state_q == DMB_IDLE);
    assign tmr_en  = (state_q == DMB_BUSY) && !bus.bus_ack_i;
`endif

    // A flush seen in this BUSY cycle discards the result just like an earlier one.
    assign drop_now = drop_q || flush_i;

    always_comb begin
        state_d = state_q;
        drop_d  = drop_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        rdata_d = rdata_q;
`ifdef DATA_MEM_BRIDGE_TIMEOUT_EN
        err_d   = 1'b0;
`endif
        unique case (state_q)
            DMB_IDLE: begin
                if (ram_ce_i && !flush_i) begin
                    we_d    = ram_we_i;
                    sel_d   = ram_sel_i;
                    adr_d   = ram_addr_i;
                    dat_d   = ram_wdata_i;
                    cyc_d   = 1'b1;
                    drop_d  = 1'b0;
                    state_d = DMB_BUSY;
                end
            end
            DMB_BUSY: begin
                drop_d = drop_now;
                if (bus.bus_ack_i) begin
                    cyc_d  = 1'b0;
                    drop_d = 1'b0;
                    if (!drop_now && !we_q) begin
                        rdata_d = bus.bus_dat_i;
                    end
                    state_d = drop_now ? DMB_IDLE : DMB_HOLD;
                end
`ifdef DATA_MEM_BRIDGE_TIMEOUT_EN
                else if (tmr_expire) begin
                    cyc_d  = 1'b0;
                    drop_d = 1'b0;
                    err_d  = 1'b1;
                    if (!drop_now) begin
                        rdata_d = 32'h0;
                    end
                    state_d = drop_now ? DMB_IDLE : DMB_HOLD;
                end
`endif
            end
            DMB_HOLD: begin
                if (!stall_i || flush_i) begin
                    state_d = DMB_IDLE;
                end
            end
            default: begin
                state_d = DMB_IDLE;
                cyc_d   = 1'b0;
                drop_d  = 1'b0;
            end
        endcase
    end

    // Reset abandons any bus cycle immediately and clears held data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DMB_IDLE;
            drop_q  <= 1'b0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= 4'h0;
            adr_q   <= 32'h0;
            dat_q   <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef DATA_MEM_BRIDGE_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.bus_err_o = err_q;
`else
    assign bus.bus_err_o = 1'b0;
`endif

    assign stallreq_o    = ((state_q == DMB_IDLE) && ram_ce_i && !flush_i) ||
                           (state_q == DMB_BUSY);
    assign ram_rdata_o   = rdata_q;
    assign bus.bus_cyc_o = cyc_q;
    assign bus.bus_stb_o = cyc_q;
    assign bus.bus_we_o  = we_q;
    assign bus.bus_sel_o = sel_q;
    assign bus.bus_adr_o = adr_q;
    assign bus.bus_dat_o = dat_q;

endmodule

// File: doc/data_mem_bridge.md
# data_mem_bridge

Sequential bridge between the combinational memory-access stage and a wait-stated, Wishbone-style data bus. It captures the stage's RAM request, runs one bus cycle per load/store, and returns read data on `ram_rdata_o`, which feeds the stage's `ram_data_i`. While the access is outstanding it raises `stallreq_o` to the pipeline controller. It holds the returned data until the pipeline advances, so a stalled instruction is never re-issued.

## Interface
- `TIMEOUT_CYCLES`, default 255: bus-wait limit in BUSY cycles. Used only with the timeout feature; valid range 1..255.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `ram_ce_i` in 1: access request from the memory stage.
- `ram_we_i` in 1: 1 = store, 0 = load.
- `ram_sel_i` in 4: byte lanes; bit 3 = bits 31:24.
- `ram_addr_i` in 32: byte address, passed unmodified.
- `ram_wdata_i` in 32: lane-aligned store data.
- `ram_rdata_o` out 32: registered load data returned to the memory stage.
- `stall_i` in 1: pipeline-controller stall for the memory stage.
- `flush_i` in 1: exception flush.
- `stallreq_o` out 1: stall request to the controller (combinational).
- `bus_cyc_o`, `bus_stb_o` out 1 each: bus cycle and strobe; always equal.
- `bus_we_o` out 1, `bus_sel_o` out 4, `bus_adr_o` out 32, `bus_dat_o` out 32: registered bus request.
- `bus_dat_i` in 32, `bus_ack_i` in 1: bus response; ack is sampled only in BUSY.
- `bus_err_o` out 1: one-cycle timeout pulse.

## Operation
- States: IDLE = 0, BUSY = 1, HOLD = 2.
- IDLE:
  - If `ram_ce_i && !flush_i`: latch we/sel/addr/wdata into the bus registers, set cyc/stb, go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - cyc/stb stay high and all bus registers are frozen.
  - On `bus_ack_i`: clear cyc/stb.
    - Load: `ram_rdata_o <= bus_dat_i`.
    - Store: `ram_rdata_o` is unchanged.
    - Next state is HOLD, or IDLE if the drop flag is set.
- Drop flag:
  - Set if `flush_i` is high in any BUSY cycle.
  - A started bus cycle is never aborted; the bridge drains to ack, then discards the result (no `ram_rdata_o` update).
  - Cleared on leaving BUSY.
- HOLD:
  - `ram_rdata_o` is stable.
  - Leave for IDLE when `stall_i == 0` or `flush_i == 1`; otherwise stay in HOLD.
  - The memory stage still presents `ram_ce_i` in HOLD; it is ignored, so no duplicate access is issued.
- `stallreq_o = (IDLE && ram_ce_i && !flush_i) || BUSY`. It is 0 in HOLD.
- Reset values:
  - state IDLE, drop flag 0.
  - All bus outputs 0.
  - `ram_rdata_o` = 32'h0, `bus_err_o` = 0.
- Reset mid-access: the bus is abandoned immediately (cyc low on the next edge) and held data is cleared.

## Timing
- Request cycle T0 is in IDLE with `stallreq_o` = 1. cyc/stb are high from T1.
- Ack in cycle Tk (k ≥ 1): state is HOLD and data is valid in Tk+1, with `stallreq_o` = 0.
- The minimum load therefore occupies the memory stage for 3 cycles.
- Back-to-back accesses: the earliest next request is sampled in the IDLE cycle after HOLD. There is at least one idle bus cycle between accesses.
- Simultaneous `bus_ack_i` and `flush_i` in BUSY: the result is dropped and the next state is IDLE.
- Simultaneous `ram_ce_i` and `flush_i` in IDLE: no access is issued.

## Configuration
- Macro `DATA_MEM_BRIDGE_TIMEOUT_EN`.
- Defined:
  - An 8-bit wait counter clears on entering BUSY and increments each BUSY cycle without ack.
  - When it reaches `TIMEOUT_CYCLES` with no ack: clear cyc/stb, set `ram_rdata_o` = 32'h0, pulse `bus_err_o` for 1 cycle.
  - Next state is HOLD, or IDLE if the drop flag is set.
  - Ack in the same cycle as the limit wins over the timeout.
- Undefined: BUSY waits indefinitely for ack, `bus_err_o` is tied 0, and the counter is not built.

## Structure
- Shared defines package holds:
  - state encodings `DMB_IDLE`, `DMB_BUSY`, `DMB_HOLD` (2-bit);
  - the default `TIMEOUT_CYCLES`.
- One sub-module, `data_mem_timer`: the wait counter with clear/enable/expire. It is instantiated only under the macro.
- Everything else is a single FSM process plus registered datapath.

## Test plan
- **Load:** `ram_ce_i` = 1, we = 0, addr = 32'h0000_0104, sel = 4'b1111; ack on the 3rd BUSY cycle with `bus_dat_i` = 32'hDEAD_BEEF.
  - `stallreq_o` is high for 4 cycles, then `ram_rdata_o` = 32'hDEAD_BEEF in HOLD.
  - Exactly one `bus_stb_o` assertion.
- **Store:** sel = 4'b0011, wdata = 32'h0000_1234; ack on the 1st BUSY cycle.
  - `bus_sel_o` = 4'b0011 and `bus_dat_o` = 32'h0000_1234 for the whole strobe.
  - `ram_rdata_o` is unchanged.
- **Stall hold:** ack arrives with `stall_i` = 1 for 5 cycles.
  - State stays HOLD, no second bus cycle, `ram_rdata_o` stable.
  - Return to IDLE the cycle after `stall_i` falls.
- **Flush while BUSY:** `flush_i` = 1 in the 2nd BUSY cycle, ack 2 cycles later with data 32'h1111_1111.
  - cyc is held until ack.
  - `ram_rdata_o` keeps its prior value; next state is IDLE.
- **Timeout (macro on, `TIMEOUT_CYCLES` = 4), no ack:**
  - cyc drops after 4 BUSY cycles.
  - `bus_err_o` pulses once; `ram_rdata_o` = 0; state HOLD.
- **Reset in BUSY:** `reset` = 1 for 1 cycle.
  - All outputs 0 on the next edge; a late ack in IDLE is ignored.
